// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 2**N requesters; a grant is held until the resource pulses done.
// Optional feature macro: ARB_TIMEOUT_EN adds a forced release after TIMEOUT cycles and the timeout output.

module rr_arbiter #(
    parameter int N       = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   req,
    input  logic              done,
    output logic [2**N-1:0]   grant,
    output logic [N-1:0]      grant_idx,
    output logic              grant_valid
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    localparam int REQ = 2**N;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [REQ-1:0]   r_grant;
    logic [N-1:0]     r_grant_idx;
    logic [N-1:0]     r_last_idx;
    logic             r_grant_valid;

    logic [REQ-1:0]   w_lower_mask;
    logic [REQ-1:0]   w_masked_req;
    logic [N-1:0]     w_masked_idx;
    logic [N-1:0]     w_full_idx;
    logic [N-1:0]     w_winner;
    logic [REQ-1:0]   w_winner_onehot;
    logic             w_req_any;

    // Priority encoder: highest set index wins.
    function automatic logic [N-1:0] f_highest(input logic [REQ-1:0] v);
        logic [N-1:0] idx;
        idx = '0;
        for (int i = 0; i < REQ; i++) begin
            if (v[i]) idx = i[N-1:0];
        end
        return idx;
    endfunction

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("rr_arbiter: TIMEOUT must be at least 1");
    end

    // Only requesters below the last winner are eligible first, so the winner rotates downward.
    for (genvar gi = 0; gi < REQ; gi++) begin : g_mask
        assign w_lower_mask[gi]    = (r_last_idx > N'(gi));
        assign w_winner_onehot[gi] = (w_winner == N'(gi));
    end

    assign w_masked_req = req & w_lower_mask;
    assign w_masked_idx = f_highest(w_masked_req);
    assign w_full_idx   = f_highest(req);
    assign w_winner     = (|w_masked_req) ? w_masked_idx : w_full_idx;
    assign w_req_any    = |req;

`ifdef ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    assign timeout = r_timeout;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_last_idx    <= '0;
`ifdef ARB_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state       <= S_BUSY;
                        r_grant       <= w_winner_onehot;
                        r_grant_idx   <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_last_idx    <= w_winner;
`ifdef ARB_TIMEOUT_EN
                        r_cnt         <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    // done wins over an expiring timeout in the same cycle.
                    if (done) begin
                        r_state       <= S_IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_LAST) begin
                        r_state       <= S_IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_timeout     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=3, TIMEOUT=4): directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
`timescale 1ns/1ps

module tb_rr_arbiter;

    localparam int N   = 3;
    localparam int REQ = 8;
    localparam int TO  = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [REQ-1:0] req;
    logic           done;
    logic [REQ-1:0] grant;
    logic [N-1:0]   grant_idx;
    logic           grant_valid;
`ifdef ARB_TIMEOUT_EN
    logic           timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit m_busy;
    int m_idx;
    int m_last;
    int m_held;
    bit m_tmo;

    rr_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout     (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin choice: first look strictly below the previous winner, then wrap to the top.
    function automatic int pick(input logic [REQ-1:0] r, input int last);
        for (int i = last - 1; i >= 0; i--) if (r[i]) return i;
        for (int i = REQ - 1; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    function automatic logic [REQ-1:0] exp_grant();
        logic [REQ-1:0] one;
        one = 8'd1;
        return m_busy ? (one << m_idx) : 8'h00;
    endfunction

    function automatic logic [N-1:0] exp_idx();
        return 3'(m_idx);
    endfunction

    // Apply one cycle of inputs, advance the model, and settle just after the edge.
    task automatic step(input logic [REQ-1:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        if (rs) begin
            m_busy = 1'b0; m_idx = 0; m_last = 0; m_held = 0; m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (!m_busy) begin
                if (r != '0) begin
                    m_idx  = pick(r, m_last);
                    m_last = m_idx;
                    m_busy = 1'b1;
                    m_held = 1;
                end
            end else if (d) begin
                m_busy = 1'b0;
            end else if (TMO_EN && m_held == TO) begin
                m_busy = 1'b0;
                m_tmo  = 1'b1;
            end else begin
                m_held++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(8'hFF, 1'b1, 1'b1);
            n_checks++;
            if ({grant, grant_idx, grant_valid} !== {8'h00, 3'd0, 1'b0}) begin
                n_errors++;
                $display("FAIL reset_hold%0d: grant=%h idx=%0d valid=%b, want 00/0/0", c, grant, grant_idx, grant_valid);
            end
        end
        step(8'h00, 1'b0, 1'b0);
        n_checks++;
        if ({grant, grant_idx, grant_valid} !== {8'h00, 3'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_after: grant=%h idx=%0d valid=%b, want 00/0/0", grant, grant_idx, grant_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_and_lock();
        step(8'b0010_1111, 1'b0, 1'b0);
        n_checks++;
        if ({grant, grant_idx, grant_valid} !== {8'b0010_0000, 3'd5, 1'b1}) begin
            n_errors++;
            $display("FAIL basic_grant: grant=%b idx=%0d valid=%b, want 00100000/5/1", grant, grant_idx, grant_valid);
        end
        step(8'h00, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(8'b1000_0000, 1'b0, 1'b0);
            n_checks++;
            if (grant !== 8'b0010_0000) begin
                n_errors++;
                $display("FAIL lock_hold%0d: grant=%b want 00100000", c, grant);
            end
        end
        step(8'b1000_0000, 1'b1, 1'b0);
        n_checks++;
        if ({grant, grant_idx, grant_valid} !== {8'h00, 3'd5, 1'b0}) begin
            n_errors++;
            $display("FAIL lock_release: grant=%b idx=%0d valid=%b, want 00000000/5/0", grant, grant_idx, grant_valid);
        end
        step(8'b1000_0000, 1'b0, 1'b0);
        n_checks++;
        if ({grant_idx, grant_valid} !== {3'd7, 1'b1}) begin
            n_errors++;
            $display("FAIL regrant7: idx=%0d valid=%b, want 7/1", grant_idx, grant_valid);
        end
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        $display("test_basic_and_lock done");
    endtask

    task automatic test_fairness();
        int want [5] = '{7, 5, 3, 1, 7};
        int prev = -1;
        step(8'b1010_1010, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(8'b1010_1010, 1'b0, 1'b0);
            $display("fair grant #%0d idx=%0d valid=%b", k, grant_idx, grant_valid);
            n_checks++;
            if (grant_valid !== 1'b1 || int'(grant_idx) != want[k] || int'(grant_idx) == prev) begin
                n_errors++;
                $display("FAIL fair_seq%0d: idx=%0d valid=%b, want %0d/1", k, grant_idx, grant_valid, want[k]);
            end
            prev = int'(grant_idx);
            step(8'b1010_1010, 1'b1, 1'b0);
            n_checks++;
            if (grant_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL fair_idle%0d: valid=%b want 0", k, grant_valid);
            end
        end
        step(8'h00, 1'b0, 1'b0);
        $display("test_fairness done");
    endtask

    task automatic test_reset_mid_grant();
        step(8'b0000_1000, 1'b0, 1'b0);
        n_checks++;
        if ({grant_idx, grant_valid} !== {3'd3, 1'b1}) begin
            n_errors++;
            $display("FAIL mid_pre: idx=%0d valid=%b, want 3/1", grant_idx, grant_valid);
        end
        step(8'b0000_1000, 1'b1, 1'b1);
        n_checks++;
        if ({grant, grant_valid} !== {8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL mid_reset: grant=%b valid=%b, want 0/0", grant, grant_valid);
        end
        step(8'b0000_1010, 1'b0, 1'b0);
        n_checks++;
        if ({grant, grant_idx, grant_valid} !== {8'b0000_1000, 3'd3, 1'b1}) begin
            n_errors++;
            $display("FAIL mid_after: grant=%b idx=%0d valid=%b, want 00001000/3/1", grant, grant_idx, grant_valid);
        end
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        $display("test_reset_mid_grant done");
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        step(8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(8'h01, 1'b0, 1'b0);
            n_checks++;
            if ({grant, grant_valid, timeout} !== {8'h01, 1'b1, 1'b0}) begin
                n_errors++;
                $display("FAIL tmo_hold%0d: grant=%b valid=%b timeout=%b, want 01/1/0", c, grant, grant_valid, timeout);
            end
        end
        step(8'h01, 1'b0, 1'b0);
        n_checks++;
        if ({grant_valid, timeout} !== {1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL tmo_fire: valid=%b timeout=%b, want 0/1", grant_valid, timeout);
        end
        step(8'h01, 1'b0, 1'b0);
        n_checks++;
        if ({grant_idx, grant_valid, timeout} !== {3'd0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL tmo_regrant: idx=%0d valid=%b timeout=%b, want 0/1/0", grant_idx, grant_valid, timeout);
        end
        for (int c = 0; c < 3; c++) step(8'h01, 1'b0, 1'b0);
        n_checks++;
        if ({grant_valid, timeout} !== {1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL tmo_cycle4: valid=%b timeout=%b, want 1/0", grant_valid, timeout);
        end
        step(8'h00, 1'b1, 1'b0);
        n_checks++;
        if ({grant_valid, timeout} !== {1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL tmo_done_wins: valid=%b timeout=%b, want 0/0", grant_valid, timeout);
        end
        $display("test_timeout done");
    endtask
`endif

    task automatic test_random();
        logic [REQ-1:0] r;
        logic d, rs;
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            d  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 49) == 0);
            step(r, d, rs);
            n_checks++;
            if ({grant, grant_idx, grant_valid} !== {exp_grant(), exp_idx(), m_busy}) begin
                n_errors++;
                $display("FAIL rand%0d: grant=%b idx=%0d valid=%b, want %b/%0d/%b",
                         c, grant, grant_idx, grant_valid, exp_grant(), exp_idx(), m_busy);
            end
            n_checks++;
            if ((grant & (grant - 8'd1)) !== 8'h00 || grant_valid !== (|grant)) begin
                n_errors++;
                $display("FAIL rand_onehot%0d: grant=%b valid=%b, want one-hot/zero with valid=|grant", c, grant, grant_valid);
            end
`ifdef ARB_TIMEOUT_EN
            n_checks++;
            if (timeout !== m_tmo) begin
                n_errors++;
                $display("FAIL rand_tmo%0d: timeout=%b want %b", c, timeout, m_tmo);
            end
`endif
        end
        step(8'h00, 1'b1, 1'b0);
        $display("test_random done");
    endtask

    initial begin
        req  = '0;
        done = 1'b0;
        rst  = 1'b1;
        m_busy = 1'b0; m_idx = 0; m_last = 0; m_held = 0; m_tmo = 1'b0;
        test_reset();
        test_basic_and_lock();
        test_fairness();
        test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among 2**N requesters, e.g. a single memory port shared by instruction fetch, data access and debug.
- Arbitration reuses the priority_encoder from the codebase: highest set index wins.
- A rotating mask prevents starvation.
- A grant is locked until the resource signals done.

Parameters:
- N, 3, log2 of the number of requesters (REQ = 2**N requesters).
- TIMEOUT, 16, maximum cycles a grant may be held. Used only with ARB_TIMEOUT_EN; must be ≥ 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req  input  2**N  per-requester request, level-sensitive.
- done  input  1  resource finished the current transaction; single-cycle pulse.
- grant  output  2**N  one-hot grant, registered.
- grant_idx  output  N  index of the granted requester, registered.
- grant_valid  output  1  a grant is active, registered.
- timeout  output  1  forced-release pulse. Port exists only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - State=IDLE, last_idx=0, timeout counter=0.
  - Reset asserted mid-grant drops the grant on the next edge. The done input is ignored while rst is high.
- Arbitration (combinational, in IDLE):
  - mask = req & ((1<<last_idx)-1).
  - If mask≠0, winner = highest set bit of mask; otherwise winner = highest set bit of req.
  - Use two priority_encoder instances (or equivalent logic).
  - With last_idx=0 the mask is empty, so plain highest-index priority applies.
- State machine:
  - IDLE:
    - req≠0 → next edge: state=BUSY, grant=1<<winner, grant_idx=winner, grant_valid=1, last_idx=winner.
    - req=0 → stay in IDLE.
    - done in IDLE is ignored.
  - BUSY:
    - grant, grant_idx and last_idx hold. Changes on req, including the granted requester dropping its request, are ignored.
    - done=1 → next edge: state=IDLE, grant=0, grant_idx holds its last value, grant_valid=0.
- Latency:
  - 1 cycle from req to grant.
  - Minimum one IDLE cycle between consecutive grants: a grant lasts at least 1 cycle, followed by at least 1 idle cycle.
- Invariants:
  - grant is always either 0 or one-hot.
  - grant_valid == |grant.
  - grant_idx equals the index of the set grant bit whenever grant_valid=1.
- Fairness: with requests held constant, every requester is granted within REQ grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An internal counter clears on entering BUSY and increments on each BUSY cycle without done.
  - Timeout occurs when counter==TIMEOUT-1 and done=0. Next edge: state=IDLE, grant=0, grant_valid=0, timeout=1 for exactly one cycle, last_idx updated as for a normal release.
  - done in the same cycle takes precedence: normal release, timeout stays 0.
  - A grant therefore lasts at most TIMEOUT cycles.
  - The counter is $clog2(TIMEOUT)+1 bits and never wraps.
- Not defined: the timeout port, counter and TIMEOUT logic are absent; a grant is held indefinitely until done.

Test Plan (N=3):
- Reset: hold rst for 2 cycles with req=8'hFF → grant=0, grant_valid=0, grant_idx=0 during reset and on the first cycle after it.
- From IDLE, req=8'b00101111 → one cycle later grant=8'b00100000, grant_idx=5, grant_valid=1.
- While granted to 5: drop req to 0, then set req=8'b10000000 for 5 cycles → grant stays 8'b00100000. Pulse done → next cycle grant_valid=0; the following cycle grant_idx=7.
- Hold req=8'b10101010 constant and pulse done one cycle after each grant → grant_idx sequence 7, 5, 3, 1, 7; never two identical in a row.
- Assert rst while grant_valid=1 (idx=3) → next edge grant=0. After release, req=8'b00001010 → grant_idx=3, because the highest index wins after reset.
- With ARB_TIMEOUT_EN, TIMEOUT=4, req=8'b00000001, no done → grant_valid=1 for exactly 4 cycles, timeout=1 for 1 cycle, one idle cycle, then re-grant idx=0. Repeat with done on cycle 4 → timeout stays 0.
